// File: rtl/gray_counter.sv
// Up/down Gray-code counter: a binary count register drives a registered
// Gray-encoded output and a one-cycle wrap pulse.
module gray_counter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] gray,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] b_next;
  logic                  wrap_next;

  // Load beats a count step; an idle or loading cycle never flags a wrap.
  always_comb begin
    b_next    = b;
    wrap_next = 1'b0;
    if (load) begin
      b_next = load_val;
    end else if (en) begin
      if (up) begin
        b_next    = b + ONE;
        wrap_next = (b == '1);
      end else begin
        b_next    = b - ONE;
        wrap_next = (b == '0);
      end
    end
  end

  // Gray is encoded from the next binary value so it stays a pure flop output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      b    <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      b    <= b_next;
      gray <= b_next ^ (b_next >> 1);
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at DATA_WIDTH = 4.
`timescale 1ns/1ps
module tb_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] gray;
  logic         wrap;

  int tests_run = 0;
  int tests_failed = 0;

  gray_counter #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .gray     (gray),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Apply inputs for one edge, then settle 1ns past it for sampling.
  task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (gray !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_gray: got %b expected 0000", gray);
    end
    tests_run++;
    if (wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wrap: got %b expected 0", wrap);
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] exp_seq [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0);
      tests_run++;
      if (gray !== exp_seq[i] || wrap !== 1'b0) begin
        tests_failed++;
        $display("FAIL count_up[%0d]: got gray=%b wrap=%b expected gray=%b wrap=0", i, gray, wrap, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hold();
    // Continues from gray=0110 (B=4)
    drive(1'b0, 1'b1, 1'b0, 4'b1111);
    tests_run++;
    if (gray !== 4'b0110 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold: got gray=%b wrap=%b expected gray=0110 wrap=0", gray, wrap);
    end
  endtask

  task automatic test_load_wrap();
    drive(1'b0, 1'b0, 1'b1, 4'b1111);
    tests_run++;
    if (gray !== 4'b1000 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_ones: got gray=%b wrap=%b expected gray=1000 wrap=0", gray, wrap);
    end
    drive(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (gray !== 4'b0000 || wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_up: got gray=%b wrap=%b expected gray=0000 wrap=1", gray, wrap);
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    tests_run++;
    if (gray !== 4'b0000 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_up_pulse_end: got gray=%b wrap=%b expected gray=0000 wrap=0", gray, wrap);
    end
  endtask

  task automatic test_down_wrap();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    tests_run++;
    if (gray !== 4'b1000 || wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_down: got gray=%b wrap=%b expected gray=1000 wrap=1", gray, wrap);
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    tests_run++;
    if (gray !== 4'b1001 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_after_wrap: got gray=%b wrap=%b expected gray=1001 wrap=0", gray, wrap);
    end
  endtask

  task automatic test_load_priority();
    // B=15 so an up step would wrap; load must win and suppress wrap.
    drive(1'b0, 1'b0, 1'b1, 4'b1111);
    drive(1'b1, 1'b1, 1'b1, 4'b0101);
    tests_run++;
    if (gray !== 4'b0111 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_priority: got gray=%b wrap=%b expected gray=0111 wrap=0", gray, wrap);
    end
    // B=0 with down requested alongside load of 0: still no wrap.
    drive(1'b0, 1'b0, 1'b1, 4'b0000);
    drive(1'b1, 1'b0, 1'b1, 4'b1010);
    tests_run++;
    if (gray !== 4'b1111 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_priority_down: got gray=%b wrap=%b expected gray=1111 wrap=0", gray, wrap);
    end
  endtask

  task automatic test_back_to_back();
    logic         dir   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_g [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b0000};
    logic         exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, dir[i], 1'b0, '0);
      tests_run++;
      if (gray !== exp_g[i] || wrap !== exp_w[i]) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got gray=%b wrap=%b expected gray=%b wrap=%b",
                 i, gray, wrap, exp_g[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_free_run();
    logic [W-1:0] prev;
    logic [W-1:0] model_b;
    int           wraps;
    apply_reset();
    model_b = '0;
    for (int d = 0; d < 2; d++) begin
      wraps = 0;
      for (int i = 0; i < 32; i++) begin
        prev = gray;
        drive(1'b1, (d == 0), 1'b0, '0);
        model_b = (d == 0) ? model_b + 4'd1 : model_b - 4'd1;
        if (wrap === 1'b1) wraps++;
        tests_run++;
        if ($countones(prev ^ gray) != 1 || gray !== (model_b ^ (model_b >> 1))) begin
          tests_failed++;
          $display("FAIL free_run_step[%0d][%0d]: got gray=%b prev=%b expected gray=%b",
                   d, i, gray, prev, model_b ^ (model_b >> 1));
        end
      end
      tests_run++;
      if (wraps != 2) begin
        tests_failed++;
        $display("FAIL free_run_wraps[%0d]: got %0d expected 2", d, wraps);
      end
    end
    tests_run++;
    if (gray !== 4'b0000) begin
      tests_failed++;
      $display("FAIL free_run_final: got gray=%b expected 0000", gray);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (4) drive(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (gray !== 4'b0110) begin
      tests_failed++;
      $display("FAIL async_pre: got gray=%b expected 0110", gray);
    end
    // Pull reset 3ns after the edge; outputs must clear before the next edge.
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (gray !== 4'b0000 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_clear: got gray=%b wrap=%b expected gray=0000 wrap=0", gray, wrap);
    end
    // Inputs active during reset are ignored.
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    tests_run++;
    if (gray !== 4'b0000 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ignores_inputs: got gray=%b wrap=%b expected gray=0000 wrap=0", gray, wrap);
    end
    load = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 1'b1, 1'b0, '0);
    tests_run++;
    if (gray !== 4'b0001 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_after_reset: got gray=%b wrap=%b expected gray=0001 wrap=0", gray, wrap);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_hold();
    test_load_wrap();
    test_down_wrap();
    test_load_priority();
    test_back_to_back();
    test_free_run();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000ns");
    $fatal(1);
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001: Parameter DATA_WIDTH, default 16, SHALL set the counter width in bits (minimum 2).
REQ-002: clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003: resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004: en  input  1  SHALL request one count step in the current cycle.
REQ-005: up  input  1  SHALL select the step direction: 1 = increment, 0 = decrement (binary sense).
REQ-006: load  input  1  SHALL request a parallel load of load_val in the current cycle.
REQ-007: load_val  input  DATA_WIDTH  SHALL be the binary value loaded when load=1.
REQ-008: gray  output  DATA_WIDTH  SHALL be the registered Gray-code encoding of the internal binary count.
REQ-009: wrap  output  1  SHALL be a registered single-cycle pulse flagging a step that wrapped around.

Function
REQ-010: The block SHALL hold an internal DATA_WIDTH-bit binary count register B.
REQ-011: Encoding rule: gray SHALL equal B XOR (B >> 1) as a registered value, never a combinational function of the inputs.
REQ-012: Priority per edge: load > en > hold.
REQ-013: load=1: B SHALL take load_val; wrap SHALL be 0 on the next cycle, regardless of en/up.
REQ-014: load=0, en=1, up=1: B SHALL take B+1, modulo 2^DATA_WIDTH.
REQ-015: load=0, en=1, up=0: B SHALL take B-1, modulo 2^DATA_WIDTH.
REQ-016: load=0, en=0: B and gray SHALL hold; wrap SHALL be 0 on the next cycle.
REQ-017: Latency: the new gray value and wrap SHALL be visible one cycle after the sampling edge (registered, 1-cycle).
REQ-018: Wrap-around up: step from B = all-ones SHALL give B = 0 and wrap = 1 for exactly one cycle.
REQ-019: Wrap-around down: step from B = 0 SHALL give B = all-ones and wrap = 1 for exactly one cycle.
REQ-020: Every en-driven step (including wrap) SHALL change exactly one bit of gray (Hamming distance 1).
REQ-021: A load SHALL NOT be constrained to Hamming distance 1 (arbitrary jumps are legal).
REQ-022: Back-to-back en with alternating up SHALL step alternately with no bubble; each cycle is independent.
REQ-023: gray and wrap SHALL be glitch-free register outputs suitable for direct sampling by a Gray-to-binary stage or a clock-domain synchronizer.

Reset
REQ-024: resetn=0 SHALL immediately (asynchronously) force B = 0, gray = 0, wrap = 0.
REQ-025: During reset, en and load SHALL be ignored; outputs hold zero.
REQ-026: Reset asserted mid-count SHALL abort the count; the first edge after deassertion with en=1, up=1 SHALL produce gray = 0...01.
REQ-027: Reset deassertion SHALL be accepted on any edge; no step occurs on the deasserting edge unless en/load are sampled high on it.

Verification (DATA_WIDTH = 4)
REQ-028: Reset, then en=1, up=1 for 4 cycles -> gray sequence 0001, 0011, 0010, 0110; wrap stays 0.
REQ-029: load=1, load_val=1111 -> gray=1000 next cycle, wrap=0; then en=1, up=1 -> gray=0000, wrap=1 for one cycle, then wrap=0.
REQ-030: From reset (B=0), en=1, up=0 -> gray=1000, wrap=1; next en=1, up=0 -> gray=1001, wrap=0.
REQ-031: load=1, en=1, up=1, load_val=0101 in same cycle -> gray=0111 (load wins), wrap=0.
REQ-032: Free-run 32 up steps then 32 down steps -> every adjacent gray pair differs in exactly one bit; wrap pulses exactly twice in each direction; final gray=0000.
REQ-033: Assert resetn=0 between clock edges while counting at gray=0110 -> gray and wrap go to 0 without waiting for clk; after release, counting restarts from 0000.
